// File: rtl/e203_ifu_pcgen_fetch_if.sv
// Fetch-unit bus bundle: memory request/response, BPU, EXU dispatch and flush.
// master = the fetch sequencer, slave = everything around it.
interface e203_ifu_pcgen_fetch_if #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned INSTR_SIZE = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_pc;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr;
  logic                  ifu_rsp_err;
  logic                  dec_is_16b;
  logic                  dec_i_valid;
  logic [PC_SIZE-1:0]    ir_pc;
  logic [INSTR_SIZE-1:0] ir_instr;
  logic                  prdt_taken;
  logic [PC_SIZE-1:0]    prdt_pc_add_op1;
  logic [PC_SIZE-1:0]    prdt_pc_add_op2;
  logic                  bpu_wait;
  logic                  ifu_o_valid;
  logic                  ifu_o_ready;
  logic                  ifu_o_err;
  logic                  ifu_o_prdt_taken;
  logic                  pipe_flush_req;
  logic [PC_SIZE-1:0]    pipe_flush_add_op1;
  logic [PC_SIZE-1:0]    pipe_flush_add_op2;
  logic                  pipe_flush_ack;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready, dec_i_valid, ir_pc, ir_instr,
           ifu_o_valid, ifu_o_err, ifu_o_prdt_taken, pipe_flush_ack,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, dec_is_16b,
           prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu_wait, ifu_o_ready,
           pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready, dec_i_valid, ir_pc, ir_instr,
           ifu_o_valid, ifu_o_err, ifu_o_prdt_taken, pipe_flush_ack,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, dec_is_16b,
           prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu_wait, ifu_o_ready,
           pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2
  );
endinterface

// File: rtl/e203_ifu_pcgen_fetch.sv
// Next-PC generator with a single-outstanding fetch sequencer and IR holding register.
// Cycles REQ -> RSP -> HOLD per instruction; EXU flushes redirect from any non-reset state.
module e203_ifu_pcgen_fetch #(
  parameter int unsigned        PC_SIZE    = 32,
  parameter int unsigned        INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RST_VEC    = PC_SIZE'(32'h0000_1000)
) (
  input logic                     clk,
  input logic                     rst_n,
  e203_ifu_pcgen_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [PC_SIZE-1:0]    nxt_pc_q,   nxt_pc_d;
  logic                  ir_valid_q, ir_valid_d;
  logic [PC_SIZE-1:0]    ir_pc_q,    ir_pc_d;
  logic [INSTR_SIZE-1:0] ir_instr_q, ir_instr_d;
  logic                  err_q,      err_d;

  logic                  req_valid_c;
  logic                  rsp_ready_c;
  logic                  dec_i_valid_c;
  logic                  o_valid_c;
  logic                  o_prdt_taken_c;
  logic                  flush_ack_c;

  logic [PC_SIZE-1:0]    flush_sum_c;
  logic [PC_SIZE-1:0]    prdt_sum_c;
  logic [PC_SIZE-1:0]    flush_tgt_c;
  logic [PC_SIZE-1:0]    prdt_tgt_c;
  logic [PC_SIZE-1:0]    seq_pc_c;
  logic                  taken_eff_c;

  // Redirect targets are halfword aligned; a faulted fetch never follows a prediction.
  assign flush_sum_c = bus.pipe_flush_add_op1 + bus.pipe_flush_add_op2;
  assign prdt_sum_c  = bus.prdt_pc_add_op1 + bus.prdt_pc_add_op2;
  assign flush_tgt_c = {flush_sum_c[PC_SIZE-1:1], 1'b0};
  assign prdt_tgt_c  = {prdt_sum_c[PC_SIZE-1:1], 1'b0};
  assign seq_pc_c    = ir_pc_q + (bus.dec_is_16b ? PC_SIZE'(2) : PC_SIZE'(4));
  assign taken_eff_c = bus.prdt_taken & ~err_q;

  always_comb begin
    state_d        = state_q;
    nxt_pc_d       = nxt_pc_q;
    ir_valid_d     = ir_valid_q;
    ir_pc_d        = ir_pc_q;
    ir_instr_d     = ir_instr_q;
    err_d          = err_q;
    req_valid_c    = 1'b0;
    rsp_ready_c    = 1'b0;
    dec_i_valid_c  = 1'b0;
    o_valid_c      = 1'b0;
    o_prdt_taken_c = 1'b0;
    flush_ack_c    = 1'b0;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        req_valid_c = ~bus.pipe_flush_req;
        if (bus.pipe_flush_req) begin
          flush_ack_c = 1'b1;
          nxt_pc_d    = flush_tgt_c;
        end else if (bus.ifu_req_ready) begin
          state_d = ST_RSP;
        end
      end

      // The outstanding response is always consumed; a pending flush discards it.
      ST_RSP: begin
        rsp_ready_c = 1'b1;
        if (bus.ifu_rsp_valid) begin
          state_d = ST_REQ;
          if (bus.pipe_flush_req) begin
            flush_ack_c = 1'b1;
            nxt_pc_d    = flush_tgt_c;
          end else begin
            ir_valid_d = 1'b1;
            ir_instr_d = bus.ifu_rsp_instr;
            err_d      = bus.ifu_rsp_err;
            ir_pc_d    = nxt_pc_q;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        dec_i_valid_c  = ir_valid_q;
        o_valid_c      = ir_valid_q & ~bus.bpu_wait & ~bus.pipe_flush_req;
        o_prdt_taken_c = ir_valid_q & taken_eff_c;
        if (bus.pipe_flush_req) begin
          flush_ack_c = 1'b1;
          nxt_pc_d    = flush_tgt_c;
          ir_valid_d  = 1'b0;
          state_d     = ST_REQ;
        end else if (o_valid_c && bus.ifu_o_ready) begin
          nxt_pc_d   = taken_eff_c ? prdt_tgt_c : seq_pc_c;
          ir_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RST;
      nxt_pc_q   <= RST_VEC;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= '0;
      ir_instr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_pc_q   <= nxt_pc_d;
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= ir_pc_d;
      ir_instr_q <= ir_instr_d;
      err_q      <= err_d;
    end
  end

  assign bus.ifu_req_valid    = req_valid_c;
  assign bus.ifu_req_pc       = nxt_pc_q;
  assign bus.ifu_rsp_ready    = rsp_ready_c;
  assign bus.dec_i_valid      = dec_i_valid_c;
  assign bus.ir_pc            = ir_pc_q;
  assign bus.ir_instr         = ir_instr_q;
  assign bus.ifu_o_valid      = o_valid_c;
  assign bus.ifu_o_err        = err_q;
  assign bus.ifu_o_prdt_taken = o_prdt_taken_c;
  assign bus.pipe_flush_ack   = flush_ack_c;

endmodule

// File: tb/tb_e203_ifu_pcgen_fetch.sv
// Bench for e203_ifu_pcgen_fetch: directed and randomized fetch/dispatch/flush sequences
// checked against a transaction-level next-PC model.
module tb_e203_ifu_pcgen_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_pc;
  logic [31:0] last_instr;

  e203_ifu_pcgen_fetch_if bus ();

  e203_ifu_pcgen_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ifu_req_ready      = 1'b0;
    bus.ifu_rsp_valid      = 1'b0;
    bus.ifu_rsp_instr      = '0;
    bus.ifu_rsp_err        = 1'b0;
    bus.dec_is_16b         = 1'b0;
    bus.prdt_taken         = 1'b0;
    bus.prdt_pc_add_op1    = '0;
    bus.prdt_pc_add_op2    = '0;
    bus.bpu_wait           = 1'b0;
    bus.ifu_o_ready        = 1'b0;
    bus.pipe_flush_req     = 1'b0;
    bus.pipe_flush_add_op1 = '0;
    bus.pipe_flush_add_op2 = '0;
  endtask

  function automatic logic [31:0] tgt(input logic [31:0] a, input logic [31:0] b);
    return (a + b) & 32'hFFFF_FFFE;
  endfunction

  // Request phase: the request must be up on the first cycle and held through back-pressure.
  task automatic do_req(input int lat);
    for (int i = 0; i < lat; i++) begin
      bus.ifu_req_ready = 1'b0;
      #1;
      chk("req_valid_wait", 32'(bus.ifu_req_valid), 32'd1);
      chk("req_pc_wait", bus.ifu_req_pc, exp_pc);
      @(negedge clk);
    end
    bus.ifu_req_ready = 1'b1;
    #1;
    chk("req_valid", 32'(bus.ifu_req_valid), 32'd1);
    chk("req_pc", bus.ifu_req_pc, exp_pc);
    @(negedge clk);
    bus.ifu_req_ready = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic is16, input logic taken,
                       input logic err, input logic [31:0] op1, input logic [31:0] op2,
                       input int req_lat, input int rsp_lat, input int wait_cyc,
                       input logic flush_hold, input logic [31:0] f1, input logic [31:0] f2);
    logic [31:0] pc;
    pc = exp_pc;
    do_req(req_lat);
    for (int i = 0; i < rsp_lat; i++) begin
      #1;
      chk("rsp_ready_wait", 32'(bus.ifu_rsp_ready), 32'd1);
      chk("no_req_in_rsp", 32'(bus.ifu_req_valid), 32'd0);
      @(negedge clk);
    end
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_instr = instr;
    bus.ifu_rsp_err   = err;
    #1;
    chk("rsp_ready", 32'(bus.ifu_rsp_ready), 32'd1);
    @(negedge clk);
    bus.ifu_rsp_valid   = 1'b0;
    bus.ifu_rsp_err     = 1'b0;
    bus.dec_is_16b      = is16;
    bus.prdt_taken      = taken;
    bus.prdt_pc_add_op1 = op1;
    bus.prdt_pc_add_op2 = op2;
    for (int i = 0; i < wait_cyc; i++) begin
      bus.bpu_wait    = 1'b1;
      bus.ifu_o_ready = 1'($urandom);
      #1;
      chk("wait_dec_valid", 32'(bus.dec_i_valid), 32'd1);
      chk("wait_o_valid", 32'(bus.ifu_o_valid), 32'd0);
      chk("wait_no_req", 32'(bus.ifu_req_valid), 32'd0);
      chk("wait_ir_pc", bus.ir_pc, pc);
      chk("wait_ir_instr", bus.ir_instr, instr);
      @(negedge clk);
    end
    bus.bpu_wait    = 1'b0;
    bus.ifu_o_ready = 1'b1;
    if (flush_hold) begin
      bus.pipe_flush_req     = 1'b1;
      bus.pipe_flush_add_op1 = f1;
      bus.pipe_flush_add_op2 = f2;
      #1;
      chk("hold_flush_ack", 32'(bus.pipe_flush_ack), 32'd1);
      chk("hold_flush_no_disp", 32'(bus.ifu_o_valid), 32'd0);
      @(negedge clk);
      bus.pipe_flush_req = 1'b0;
      exp_pc = tgt(f1, f2);
    end else begin
      #1;
      chk("o_valid", 32'(bus.ifu_o_valid), 32'd1);
      chk("dec_i_valid", 32'(bus.dec_i_valid), 32'd1);
      chk("ir_pc", bus.ir_pc, pc);
      chk("ir_instr", bus.ir_instr, instr);
      chk("o_err", 32'(bus.ifu_o_err), 32'(err));
      chk("o_prdt_taken", 32'(bus.ifu_o_prdt_taken), 32'(taken & ~err));
      chk("no_ack", 32'(bus.pipe_flush_ack), 32'd0);
      @(negedge clk);
      if (taken && !err) exp_pc = tgt(op1, op2);
      else               exp_pc = pc + (is16 ? 32'd2 : 32'd4);
    end
    bus.ifu_o_ready = 1'b0;
    bus.prdt_taken  = 1'b0;
    last_instr = instr;
  endtask

  // Flush raised while a response is outstanding: ack only with the response, IR untouched.
  task automatic flush_rsp(input logic [31:0] f1, input logic [31:0] f2, input int lat);
    do_req(0);
    bus.pipe_flush_req     = 1'b1;
    bus.pipe_flush_add_op1 = f1;
    bus.pipe_flush_add_op2 = f2;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk("rsp_flush_no_ack", 32'(bus.pipe_flush_ack), 32'd0);
      chk("rsp_flush_ready", 32'(bus.ifu_rsp_ready), 32'd1);
      @(negedge clk);
    end
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_instr = $urandom;
    #1;
    chk("rsp_flush_ack", 32'(bus.pipe_flush_ack), 32'd1);
    @(negedge clk);
    bus.ifu_rsp_valid  = 1'b0;
    bus.pipe_flush_req = 1'b0;
    #1;
    chk("rsp_flush_ir_kept", bus.ir_instr, last_instr);
    chk("rsp_flush_no_dec", 32'(bus.dec_i_valid), 32'd0);
    exp_pc = tgt(f1, f2);
  endtask

  task automatic flush_req(input logic [31:0] f1, input logic [31:0] f2);
    bus.pipe_flush_req     = 1'b1;
    bus.pipe_flush_add_op1 = f1;
    bus.pipe_flush_add_op2 = f2;
    bus.ifu_req_ready      = 1'b1;
    #1;
    chk("req_flush_no_valid", 32'(bus.ifu_req_valid), 32'd0);
    chk("req_flush_ack", 32'(bus.pipe_flush_ack), 32'd1);
    @(negedge clk);
    bus.pipe_flush_req = 1'b0;
    bus.ifu_req_ready  = 1'b0;
    exp_pc = tgt(f1, f2);
  endtask

  initial begin
    idle();
    last_instr = '0;
    exp_pc     = 32'h0000_1000;

    // Reset: everything quiet, even with the memory ready.
    bus.ifu_req_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(bus.ifu_req_valid), 32'd0);
      chk("rst_rsp_ready", 32'(bus.ifu_rsp_ready), 32'd0);
      chk("rst_dec_valid", 32'(bus.dec_i_valid), 32'd0);
      chk("rst_o_valid", 32'(bus.ifu_o_valid), 32'd0);
      chk("rst_ack", 32'(bus.pipe_flush_ack), 32'd0);
      chk("rst_ir_pc", bus.ir_pc, 32'd0);
      chk("rst_ir_instr", bus.ir_instr, 32'd0);
      chk("rst_o_err", 32'(bus.ifu_o_err), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.ifu_req_ready = 1'b0;
    #1;
    chk("rst_state_no_req", 32'(bus.ifu_req_valid), 32'd0);
    @(negedge clk);

    // Directed sequence from the reset vector.
    fetch(32'h0000_0013, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0, 0, 1'b0, '0, '0);
    chk("seq32_pc", exp_pc, 32'h0000_1004);
    fetch(32'h0000_4501, 1'b1, 1'b0, 1'b0, '0, '0, 1, 1, 0, 1'b0, '0, '0);
    chk("seq16_pc", exp_pc, 32'h0000_1006);
    fetch(32'h0000_0001, 1'b1, 1'b0, 1'b0, '0, '0, 0, 2, 0, 1'b0, '0, '0);
    fetch(32'hFE00_0CE3, 1'b0, 1'b1, 1'b0, 32'h0000_1008, 32'hFFFF_FFF8, 0, 0, 0, 1'b0, '0, '0);
    chk("branch_pc", exp_pc, 32'h0000_1000);
    fetch(32'h1234_5678, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0, 3, 1'b0, '0, '0);
    flush_rsp(32'h0000_2000, 32'h0000_0010, 2);
    chk("flush_rsp_pc", exp_pc, 32'h0000_2010);
    fetch(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0, 0, 1'b1, 32'h0000_3000, 32'h0000_0004);
    chk("flush_hold_pc", exp_pc, 32'h0000_3004);
    fetch(32'hBAD0_0001, 1'b0, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_0000, 0, 1, 0, 1'b0, '0, '0);
    chk("err_seq_pc", exp_pc, 32'h0000_3008);
    flush_req(32'h0000_5001, 32'h0000_0000);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        flush_req($urandom, $urandom);
      end else if (kind == 1) begin
        flush_rsp($urandom, $urandom, int'($urandom_range(0, 3)));
      end else begin
        fetch($urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
              $urandom, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), (kind == 2), $urandom, $urandom);
      end
    end
    do_req(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
